// File: rtl/gh_pkg.sv
// Shared lane-state encoding and default sizing for the note judge, scroller and top level.
// Latency: none (types and constants only).
// Backpressure: none.
package gh_pkg;

  // Default lane count and debounce window (5 ms at 50 MHz)
  localparam int GH_LANES           = 4;
  localparam int GH_DEBOUNCE_CYCLES = 250000;

  // Per-lane judge state
  typedef enum logic [1:0] {
    LANE_EMPTY = 2'd0,
    LANE_ARMED = 2'd1,
    LANE_DONE  = 2'd2
  } lane_state_t;

endpackage

// File: rtl/key_debounce.sv
// One fret key: two-flop synchroniser, stability-counter debounce, registered rising-edge pulse.
// Latency: raw change to press_edge is 2 + DEBOUNCE_CYCLES + 1 cycles.
// Backpressure: none; press_edge is a fire-and-forget single-cycle pulse.
module key_debounce
  import gh_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = GH_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_raw,
  output logic press_edge
);

  localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic          key_db;
  logic          key_db_q;
  logic [CW-1:0] cnt;

  // Bring the asynchronous key into the clock domain
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= key_raw;
      sync_q2 <= sync_q1;
    end
  end

  // Accept a key change only after it has held for DEBOUNCE_CYCLES consecutive samples
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      key_db <= 1'b0;
      cnt    <= '0;
    end else if (sync_q2 == key_db) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      key_db <= ~key_db;
      cnt    <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // One-cycle pulse when the debounced key goes down (rises)
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      key_db_q   <= 1'b0;
      press_edge <= 1'b0;
    end else begin
      key_db_q   <= key_db;
      press_edge <= key_db & ~key_db_q;
    end
  end

endmodule

// File: rtl/note_judge.sv
// Per-lane hit/miss judge: debounced presses vs strike-zone notes, aggregated into hit/miss pulses.
// Latency: press_edge at cycle N -> note_hit/note_miss/note_clear in cycle N+1 (one pulse cycle).
// Backpressure: none; scoring and scroller must consume every single-cycle pulse.
module note_judge
  import gh_pkg::*;
#(
  parameter int LANES           = GH_LANES,
  parameter int DEBOUNCE_CYCLES = GH_DEBOUNCE_CYCLES,
  parameter bit PENALIZE_GHOST  = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [LANES-1:0] key_raw,
  input  logic [LANES-1:0] note_in_window,
  input  logic [LANES-1:0] note_expired,
  output logic             note_hit,
  output logic             note_miss,
  output logic [LANES-1:0] hit_lanes,
  output logic [LANES-1:0] note_clear
);

  logic [LANES-1:0] press_edge;
  logic [LANES-1:0] lane_hit;
  logic [LANES-1:0] lane_miss;
  lane_state_t      state_q [LANES];
  lane_state_t      state_d [LANES];

  for (genvar g = 0; g < LANES; g++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
      .clk        (clk),
      .reset_n    (reset_n),
      .key_raw    (key_raw[g]),
      .press_edge (press_edge[g])
    );
  end

  // Lane state registers
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (!reset_n) state_q[i] <= LANE_EMPTY;
      else          state_q[i] <= state_d[i];
    end
  end

  // Lane transitions; a hit on a note that is leaving goes straight back to EMPTY
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        LANE_EMPTY: if (note_in_window[i]) state_d[i] = LANE_ARMED;
        LANE_ARMED: begin
          if (press_edge[i])
            state_d[i] = (note_expired[i] || !note_in_window[i]) ? LANE_EMPTY : LANE_DONE;
          else if (note_expired[i] || !note_in_window[i])
            state_d[i] = LANE_EMPTY;
        end
        LANE_DONE:  if (note_expired[i] || !note_in_window[i]) state_d[i] = LANE_EMPTY;
        default:    state_d[i] = LANE_EMPTY;
      endcase
    end
  end

  // Per-lane events; a press outside ARMED is a ghost, which DONE uses to block double hits
  always_comb begin
    lane_hit  = '0;
    lane_miss = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_hit[i]  = (state_q[i] == LANE_ARMED) && press_edge[i];
      lane_miss[i] = ((state_q[i] == LANE_ARMED) && !press_edge[i] && note_expired[i]) ||
                     (PENALIZE_GHOST && (state_q[i] != LANE_ARMED) && press_edge[i]);
    end
  end

  // Aggregate lanes: a miss anywhere suppresses the hit pulse, but hit notes are still retired
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      note_hit   <= 1'b0;
      note_miss  <= 1'b0;
      hit_lanes  <= '0;
      note_clear <= '0;
    end else begin
      note_miss  <= |lane_miss;
      note_hit   <= ~(|lane_miss) & (|lane_hit);
      hit_lanes  <= (|lane_miss) ? '0 : lane_hit;
      note_clear <= lane_hit;
    end
  end

endmodule

// File: tb/tb_note_judge.sv
// Bench for note_judge: directed scenarios plus randomized traffic against a behavioural model.
// Two instances share stimulus: ghost presses penalised and ghost presses ignored.
// Expected values come from the scenario rules and from the model below.
module tb_note_judge;

  localparam int L = 4;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [L-1:0] key_raw;
  logic [L-1:0] win;
  logic [L-1:0] expd;

  logic         hit, miss, hit_n, miss_n;
  logic [L-1:0] hl, clr, hl_n, clr_n;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  note_judge #(.LANES(L), .DEBOUNCE_CYCLES(D), .PENALIZE_GHOST(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .key_raw(key_raw), .note_in_window(win),
    .note_expired(expd), .note_hit(hit), .note_miss(miss), .hit_lanes(hl), .note_clear(clr));

  note_judge #(.LANES(L), .DEBOUNCE_CYCLES(D), .PENALIZE_GHOST(1'b0)) dut_ng (
    .clk(clk), .reset_n(reset_n), .key_raw(key_raw), .note_in_window(win),
    .note_expired(expd), .note_hit(hit_n), .note_miss(miss_n), .hit_lanes(hl_n), .note_clear(clr_n));

  // Behavioural model: a key is "down" once its delayed sample has disagreed with the
  // accepted level for D samples in a row; a lane holds at most one live note which
  // can be scored once.
  int       run [L];
  bit       r1 [L], r2 [L], db [L], dbp [L], pe [L], new_pe;
  bit       has_note [L], scored [L];
  bit       am, ag;
  bit [L-1:0] hm;
  bit       exp_hit_pg, exp_miss_pg, exp_hit_ng, exp_miss_ng;
  bit [L-1:0] exp_hl_pg, exp_hl_ng, exp_clr;

  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < L; i++) begin
        run[i] = 0; r1[i] = 0; r2[i] = 0; db[i] = 0; dbp[i] = 0; pe[i] = 0;
        has_note[i] = 0; scored[i] = 0;
      end
      exp_hit_pg = 0; exp_miss_pg = 0; exp_hit_ng = 0; exp_miss_ng = 0;
      exp_hl_pg = '0; exp_hl_ng = '0; exp_clr = '0;
    end else begin
      am = 0; ag = 0; hm = '0;
      for (int i = 0; i < L; i++) begin
        if (!has_note[i]) begin
          if (pe[i]) ag = 1;
          has_note[i] = win[i];
          scored[i]   = 0;
        end else if (!scored[i]) begin
          if (pe[i]) begin
            hm[i] = 1;
            if (expd[i] || !win[i]) has_note[i] = 0;
            else                    scored[i]   = 1;
          end else if (expd[i]) begin
            am = 1; has_note[i] = 0;
          end else if (!win[i]) begin
            has_note[i] = 0;
          end
        end else begin
          if (pe[i]) ag = 1;
          if (expd[i] || !win[i]) begin has_note[i] = 0; scored[i] = 0; end
        end
      end
      exp_miss_pg = am | ag;
      exp_hit_pg  = !(am | ag) && (hm != 0);
      exp_hl_pg   = (am | ag) ? '0 : hm;
      exp_miss_ng = am;
      exp_hit_ng  = !am && (hm != 0);
      exp_hl_ng   = am ? '0 : hm;
      exp_clr     = hm;
      for (int i = 0; i < L; i++) begin
        new_pe = db[i] & ~dbp[i];
        dbp[i] = db[i];
        if (r2[i] != db[i]) begin
          run[i]++;
          if (run[i] == D) begin db[i] = ~db[i]; run[i] = 0; end
        end else begin
          run[i] = 0;
        end
        r2[i] = r1[i];
        r1[i] = key_raw[i];
        pe[i] = new_pe;
      end
    end
  end

  task automatic do_reset();
    reset_n = 1'b0; key_raw = '0; win = '0; expd = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; key_raw = 4'hF; win = '0; expd = '0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({hit, miss, hl, clr} !== 10'd0) begin
      n_fail++; $display("FAIL reset_outs: got %b required 0", {hit, miss, hl, clr});
    end
    n_tests++;
    if ({hit_n, miss_n, hl_n, clr_n} !== 10'd0) begin
      n_fail++; $display("FAIL reset_outs_ng: got %b required 0", {hit_n, miss_n, hl_n, clr_n});
    end
    reset_n = 1'b1;
    // Keys held through reset: ghost miss appears only after 2 sync + D + 1 edges, then judge edge
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      n_tests++;
      if (miss !== (c == 8)) begin
        n_fail++; $display("FAIL reset_latency c=%0d: miss=%b required %b", c, miss, (c == 8));
      end
      n_tests++;
      if ({hit, hit_n, miss_n} !== 3'b000) begin
        n_fail++; $display("FAIL reset_no_hit c=%0d: got %b required 000", c, {hit, hit_n, miss_n});
      end
    end
  endtask

  task automatic test_bounce();
    int hits, misses, clrs;
    logic [L-1:0] mask;
    hits = 0; misses = 0; clrs = 0; mask = '0;
    do_reset();
    win = 4'b0001;
    repeat (2) @(negedge clk);
    for (int c = 0; c < 50; c++) begin
      key_raw[0] = (c >= 20) ? 1'b1 : (((c / 2) % 2) == 0);
      @(negedge clk);
      if (hit) begin hits++; mask = hl; end
      if (miss) misses++;
      if (clr[0]) clrs++;
    end
    n_tests++;
    if (hits !== 1) begin n_fail++; $display("FAIL bounce_hits: got %0d required 1", hits); end
    n_tests++;
    if (mask !== 4'b0001) begin n_fail++; $display("FAIL bounce_mask: got %b required 0001", mask); end
    n_tests++;
    if (clrs !== 1) begin n_fail++; $display("FAIL bounce_clear: got %0d required 1", clrs); end
    n_tests++;
    if (misses !== 0) begin n_fail++; $display("FAIL bounce_miss: got %0d required 0", misses); end
  endtask

  task automatic test_expire();
    int bad;
    bad = 0;
    do_reset();
    win = 4'b0100;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (hit || miss) bad++;
    end
    n_tests++;
    if (bad !== 0) begin n_fail++; $display("FAIL expire_quiet: got %0d pulses required 0", bad); end
    expd = 4'b0100;
    @(negedge clk);
    n_tests++;
    if ({miss, hit} !== 2'b10) begin
      n_fail++; $display("FAIL expire_miss: miss,hit=%b required 10", {miss, hit});
    end
    expd = '0; win = '0;
    @(negedge clk);
    n_tests++;
    if ({miss, hit} !== 2'b00) begin
      n_fail++; $display("FAIL expire_one_cycle: miss,hit=%b required 00", {miss, hit});
    end
  endtask

  task automatic test_chord();
    int hits, misses;
    logic [L-1:0] mask, cmask;
    hits = 0; misses = 0; mask = '0; cmask = '0;
    do_reset();
    win = 4'b1001;
    repeat (2) @(negedge clk);
    key_raw = 4'b1001;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (hit) begin hits++; mask = hl; end
      if (miss) misses++;
      cmask |= clr;
    end
    n_tests++;
    if (hits !== 1) begin n_fail++; $display("FAIL chord_hits: got %0d required 1", hits); end
    n_tests++;
    if (mask !== 4'b1001) begin n_fail++; $display("FAIL chord_mask: got %b required 1001", mask); end
    n_tests++;
    if (cmask !== 4'b1001) begin n_fail++; $display("FAIL chord_clear: got %b required 1001", cmask); end
    n_tests++;
    if (misses !== 0) begin n_fail++; $display("FAIL chord_hold: got %0d misses required 0", misses); end
    key_raw[0] = 1'b0;
    repeat (12) @(negedge clk);
    key_raw[0] = 1'b1;
    hits = 0; misses = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (hit) hits++;
      if (miss) misses++;
    end
    n_tests++;
    if ({hits, misses} !== {32'd0, 32'd1}) begin
      n_fail++; $display("FAIL chord_repress: hits=%0d misses=%0d required 0 1", hits, misses);
    end
  endtask

  task automatic test_conflict();
    do_reset();
    win = 4'b0110;
    repeat (2) @(negedge clk);
    key_raw = 4'b0010;
    repeat (7) @(negedge clk);
    expd = 4'b0100;
    @(negedge clk);
    n_tests++;
    if ({miss, hit, hl, clr} !== {2'b10, 4'b0000, 4'b0010}) begin
      n_fail++; $display("FAIL conflict_lanes: miss,hit,hl,clr=%b required 10_0000_0010", {miss, hit, hl, clr});
    end
    expd = '0; win = '0;
    do_reset();
    win = 4'b1000;
    repeat (2) @(negedge clk);
    key_raw = 4'b1000;
    repeat (7) @(negedge clk);
    expd = 4'b1000;
    @(negedge clk);
    n_tests++;
    if ({miss, hit, hl, clr} !== {2'b01, 4'b1000, 4'b1000}) begin
      n_fail++; $display("FAIL conflict_same_lane: miss,hit,hl,clr=%b required 01_1000_1000", {miss, hit, hl, clr});
    end
    expd = '0; win = '0;
  endtask

  task automatic test_ghost_and_reset();
    int ng_pulses, pg_miss, pulses;
    ng_pulses = 0; pg_miss = 0; pulses = 0;
    do_reset();
    key_raw = 4'b0100;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (hit_n || miss_n || clr_n != 0) ng_pulses++;
      if (miss) pg_miss++;
    end
    n_tests++;
    if (ng_pulses !== 0) begin n_fail++; $display("FAIL ghost_off: got %0d pulses required 0", ng_pulses); end
    n_tests++;
    if (pg_miss !== 1) begin n_fail++; $display("FAIL ghost_on: got %0d misses required 1", pg_miss); end
    do_reset();
    win = 4'b0001;
    repeat (2) @(negedge clk);
    key_raw = 4'b0001;
    repeat (7) @(negedge clk);
    reset_n = 1'b0; key_raw = '0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (hit || miss || clr != 0 || hit_n || miss_n) pulses++;
      @(negedge clk);
    end
    n_tests++;
    if (pulses !== 0) begin n_fail++; $display("FAIL reset_discard: got %0d pulses required 0", pulses); end
    win = '0;
  endtask

  task automatic test_random();
    bit [L-1:0] drop;
    int r;
    drop = '0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      n_tests++;
      if ({hit, miss, hl, clr} !== {exp_hit_pg, exp_miss_pg, exp_hl_pg, exp_clr}) begin
        n_fail++;
        $display("FAIL rand_pg c=%0d: hit,miss,hl,clr=%b required %b", c,
                 {hit, miss, hl, clr}, {exp_hit_pg, exp_miss_pg, exp_hl_pg, exp_clr});
      end
      n_tests++;
      if ({hit_n, miss_n, hl_n, clr_n} !== {exp_hit_ng, exp_miss_ng, exp_hl_ng, exp_clr}) begin
        n_fail++;
        $display("FAIL rand_ng c=%0d: hit,miss,hl,clr=%b required %b", c,
                 {hit_n, miss_n, hl_n, clr_n}, {exp_hit_ng, exp_miss_ng, exp_hl_ng, exp_clr});
      end
      reset_n = ($urandom_range(0, 499) != 0);
      for (int i = 0; i < L; i++) begin
        if ($urandom_range(0, 5) == 0) key_raw[i] = ~key_raw[i];
        expd[i] = 1'b0;
        if (drop[i]) begin
          win[i] = 1'b0; drop[i] = 1'b0;
        end else if (win[i]) begin
          r = $urandom_range(0, 11);
          if (r == 0) begin expd[i] = 1'b1; drop[i] = 1'b1; end
          else if (r == 1) win[i] = 1'b0;
        end else begin
          if ($urandom_range(0, 9) == 0) win[i] = 1'b1;
          else if ($urandom_range(0, 29) == 0) expd[i] = 1'b1;
        end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    reset_n = 1'b0; key_raw = '0; win = '0; expd = '0;
    @(negedge clk);
    test_reset();
    test_bounce();
    test_expire();
    test_chord();
    test_conflict();
    test_ghost_and_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
